// File: rtl/master_seq_pkg.sv
// master_seq_pkg: shared FSM state type and default parameter values for master_sequencer.
//   Contents: state_t (IDLE, START, WAIT, CHECK, DONE) and DEF_* parameter defaults.
package master_seq_pkg;
   typedef enum logic [2:0] {IDLE, START, WAIT, CHECK, DONE} state_t;
   localparam int DEF_NUM_SLAVES = 30;
   localparam int DEF_NUM_SECTS  = 16;
   localparam int DEF_RES_W      = 9;
   localparam int DEF_CORNER_W   = 36;
   localparam int DEF_TIMEOUT    = 1024;
endpackage

// File: rtl/master_sequencer_sect_counter.sv
// sect_counter: section number up-counter with synchronous clear/enable and terminal-count flag.
//   clk, rst : clock and synchronous active-high reset
//   clr      : force count to 0 (wins over en)
//   en       : increment count
//   q        : current section number
//   tc       : high when q == NUM_SECTS-1
module sect_counter import master_seq_pkg::*; #(
   parameter int NUM_SECTS = DEF_NUM_SECTS,
   parameter int SECT_W    = $clog2(NUM_SECTS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   output logic [SECT_W-1:0] q,
   output logic              tc
);
   assign tc = q == SECT_W'(NUM_SECTS - 1);
   always_ff @(posedge clk) begin
      if (rst || clr) q <= '0;
      else if (en) q <= q + 1'b1;
   end
endmodule

// File: rtl/master_sequencer.sv
// master_sequencer: walks one rasterisation job through every section of a frame.
//   clk, rst        : clock, synchronous active-high reset
//   res, corner     : job data, latched into res_q/corner_q on accept
//   new_input       : job request, accepted only in IDLE without abort
//   abort           : cancel current frame, returns to IDLE
//   slave_mask      : participating slaves, latched on accept
//   ready           : per-slave section-done flags
//   start           : one-cycle pulse at the beginning of each section
//   sectnum         : current section number
//   busy            : high in every state except IDLE
//   frame_done      : one-cycle pulse after the last section
//   timeout_err     : sticky watchdog flag, cleared on accept
//   input_dropped   : registered pulse for a request that could not be accepted
module master_sequencer import master_seq_pkg::*; #(
   parameter  int NUM_SLAVES = DEF_NUM_SLAVES,
   parameter  int NUM_SECTS  = DEF_NUM_SECTS,
   parameter  int RES_W      = DEF_RES_W,
   parameter  int CORNER_W   = DEF_CORNER_W,
   parameter  int TIMEOUT    = DEF_TIMEOUT,
   localparam int SECT_W     = $clog2(NUM_SECTS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [RES_W-1:0]      res,
   input  logic [CORNER_W-1:0]   corner,
   input  logic                  new_input,
   input  logic                  abort,
   input  logic [NUM_SLAVES-1:0] slave_mask,
   input  logic [NUM_SLAVES-1:0] ready,
   output logic                  start,
   output logic [SECT_W-1:0]     sectnum,
   output logic [RES_W-1:0]      res_q,
   output logic [CORNER_W-1:0]   corner_q,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  timeout_err,
   output logic                  input_dropped
);
   // Wide enough to hold TIMEOUT; saturates so a disabled watchdog never wraps into the guard value.
   localparam int WD_W = $clog2(TIMEOUT + 2);
   state_t                  state, state_n;
   logic [NUM_SLAVES-1:0]   mask_q;
   logic [WD_W-1:0]         wd;
   logic                    accept, cnt_clr, cnt_en, tc, guard, hit, expire, fire;
   // wd == 0 marks the first WAIT cycle, where stale ready flags are ignored.
   assign guard  = wd == '0;
   assign hit    = !guard && &(ready | ~mask_q);
   assign expire = TIMEOUT != 0 && wd == WD_W'(TIMEOUT);
   assign start      = state == START;
   assign busy       = state != IDLE;
   assign frame_done = state == DONE;
   sect_counter #(.NUM_SECTS(NUM_SECTS), .SECT_W(SECT_W)) u_sect (
      .clk(clk), .rst(rst), .clr(cnt_clr), .en(cnt_en), .q(sectnum), .tc(tc)
   );
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      fire    = 1'b0;
      if (state != IDLE && abort) begin
         state_n = IDLE;
         cnt_clr = 1'b1;
      end else begin
         case (state)
            IDLE: if (new_input && !abort) begin
               accept  = 1'b1;
               cnt_clr = 1'b1;
               state_n = START;
            end
            START: state_n = WAIT;
            WAIT: begin
               state_n = hit ? CHECK : expire ? IDLE : WAIT;
               fire    = !hit && expire;
            end
            CHECK: begin
               state_n = tc ? DONE : START;
               cnt_clr = tc;
               cnt_en  = !tc;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q         <= '0;
         corner_q      <= '0;
         mask_q        <= '0;
         wd            <= '0;
         timeout_err   <= 1'b0;
         input_dropped <= 1'b0;
      end else begin
         input_dropped <= new_input && (state != IDLE || abort);
         wd            <= state != WAIT ? '0 : &wd ? wd : wd + 1'b1;
         if (accept) begin
            res_q       <= res;
            corner_q    <= corner;
            mask_q      <= slave_mask;
            timeout_err <= 1'b0;
         end else if (fire) begin
            timeout_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_master_sequencer.sv
// tb_master_sequencer: directed vector table plus multi-cycle sequences for master_sequencer.
module tb_master_sequencer;
   localparam int NS = 30;
   logic clk = 1'b0, rst = 1'b1;
   logic [8:0] res = '0;
   logic [35:0] corner = '0;
   logic new_input = 1'b0, abort = 1'b0;
   logic [NS-1:0] slave_mask = '1, ready = '0;
   logic start, busy, frame_done, timeout_err, input_dropped;
   logic [3:0] sectnum;
   logic [8:0] res_q;
   logic [35:0] corner_q;
   logic start_t, busy_t, frame_done_t, timeout_err_t, input_dropped_t;
   logic [3:0] sectnum_t;
   logic [8:0] res_q_t;
   logic [35:0] corner_q_t;
   int n_vec = 0, n_bad = 0;
   master_sequencer dut (
      .clk(clk), .rst(rst), .res(res), .corner(corner), .new_input(new_input), .abort(abort),
      .slave_mask(slave_mask), .ready(ready), .start(start), .sectnum(sectnum), .res_q(res_q),
      .corner_q(corner_q), .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
      .input_dropped(input_dropped)
   );
   master_sequencer #(.TIMEOUT(8)) dut_t (
      .clk(clk), .rst(rst), .res(res), .corner(corner), .new_input(new_input), .abort(abort),
      .slave_mask(slave_mask), .ready(ready), .start(start_t), .sectnum(sectnum_t), .res_q(res_q_t),
      .corner_q(corner_q_t), .busy(busy_t), .frame_done(frame_done_t), .timeout_err(timeout_err_t),
      .input_dropped(input_dropped_t)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic ni, ab, rdy, st, bz;
      logic [3:0] sn;
      logic fd, dr;
   } vec_t;
   function automatic vec_t mk(input int ni, ab, rdy, st, bz, sn, fd, dr);
      vec_t v;
      v.ni = ni[0]; v.ab = ab[0]; v.rdy = rdy[0]; v.st = st[0];
      v.bz = bz[0]; v.sn = sn[3:0]; v.fd = fd[0]; v.dr = dr[0];
      return v;
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1; new_input = 1'b0; abort = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask
   // Cycle c is the cycle after the c-th edge counted from the accept edge (c=1 is START of section 0).
   task automatic run_frame(input bit inject, input logic [8:0] r, input logic [35:0] k);
      int sn;
      bit pulse;
      slave_mask = '1; ready = '1;
      for (int c = 1; c <= 68; c++) begin
         pulse = inject && (c == 15 || c == 66);
         new_input = (c == 1) || pulse;
         res = pulse ? ~r : r;
         corner = pulse ? ~k : k;
         step();
         sn = (c <= 64) ? (c - 1) / 4 : 0;
         chk($sformatf("start@%0d", c), start, (c <= 61 && c % 4 == 1));
         chk($sformatf("sectnum@%0d", c), sectnum, sn[3:0]);
         chk($sformatf("frame_done@%0d", c), frame_done, c == 65);
         chk($sformatf("busy@%0d", c), busy, c <= 65);
         chk($sformatf("dropped@%0d", c), input_dropped, pulse);
         chk($sformatf("job_q@%0d", c), {res_q, corner_q}, {r, k});
         chk($sformatf("terr@%0d", c), timeout_err, 1'b0);
      end
      new_input = 1'b0;
   endtask
   vec_t tbl[15];
   initial begin
      int cnt, last, starts, nst, quiet;
      bit seen;
      repeat (3) step();
      chk("reset_outs", {start, sectnum, res_q, corner_q, busy, frame_done, timeout_err, input_dropped}, 0);
      chk("reset_outs_t", {start_t, sectnum_t, res_q_t, corner_q_t, busy_t, frame_done_t, timeout_err_t, input_dropped_t}, 0);
      rst = 1'b0;
      //            ni ab rdy  st bz sn fd dr
      tbl[0]  = mk(0, 0, 1,   0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 1,   1, 1, 0, 0, 0);
      tbl[2]  = mk(0, 0, 1,   0, 1, 0, 0, 0);
      tbl[3]  = mk(0, 0, 1,   0, 1, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0,   0, 1, 0, 0, 0);
      tbl[5]  = mk(0, 0, 1,   0, 1, 0, 0, 0);
      tbl[6]  = mk(0, 0, 1,   1, 1, 1, 0, 0);
      tbl[7]  = mk(1, 0, 1,   0, 1, 1, 0, 1);
      tbl[8]  = mk(0, 0, 1,   0, 1, 1, 0, 0);
      tbl[9]  = mk(0, 0, 1,   0, 1, 1, 0, 0);
      tbl[10] = mk(0, 0, 1,   1, 1, 2, 0, 0);
      tbl[11] = mk(0, 0, 1,   0, 1, 2, 0, 0);
      tbl[12] = mk(0, 1, 1,   0, 0, 0, 0, 0);
      tbl[13] = mk(1, 1, 1,   0, 0, 0, 0, 1);
      tbl[14] = mk(0, 0, 1,   0, 0, 0, 0, 0);
      res = 9'h055; corner = 36'h0_1234_5678;
      for (int i = 0; i < 15; i++) begin
         new_input = tbl[i].ni; abort = tbl[i].ab; ready = tbl[i].rdy ? '1 : '0;
         step();
         chk($sformatf("vec%0d", i), {start, busy, sectnum, frame_done, input_dropped, timeout_err},
             {tbl[i].st, tbl[i].bz, tbl[i].sn, tbl[i].fd, tbl[i].dr, 1'b0});
      end
      new_input = 1'b0; abort = 1'b0;
      run_frame(1'b0, 9'h1a5, 36'h1_2345_6789);
      run_frame(1'b1, 9'h0f0, 36'hA_BCDE_F012);
      // Masked slaves 0-1 raise ready 10 cycles after each start; others stay low.
      do_reset();
      slave_mask = 30'h3; ready = '0; res = 9'h011; corner = 36'h5;
      cnt = 0; last = -1; starts = 0; seen = 1'b0;
      for (int c = 1; c <= 300 && !seen; c++) begin
         new_input = (c == 1);
         step();
         if (start) begin
            if (last >= 0) chk($sformatf("b_spacing@%0d", c), c - last, 12);
            last = c; starts++; cnt = 0;
         end else cnt++;
         ready = {28'b0, (cnt >= 10) ? 2'b11 : 2'b00};
         if (frame_done) seen = 1'b1;
      end
      new_input = 1'b0;
      chk("b_done_seen", seen, 1'b1);
      chk("b_starts", starts, 16);
      chk("b_terr", timeout_err, 1'b0);
      // Watchdog on the TIMEOUT=8 instance with ready held low.
      do_reset();
      slave_mask = '1; ready = '0;
      for (int c = 1; c <= 10; c++) begin
         new_input = (c == 1);
         step();
         chk($sformatf("c_busy@%0d", c), busy_t, 1'b1);
         chk($sformatf("c_terr@%0d", c), timeout_err_t, 1'b0);
         chk($sformatf("c_done@%0d", c), frame_done_t, 1'b0);
      end
      new_input = 1'b0;
      step();
      chk("c_fire", {busy_t, timeout_err_t, frame_done_t}, 3'b010);
      step();
      chk("c_sticky", {busy_t, timeout_err_t, frame_done_t}, 3'b010);
      new_input = 1'b1;
      step();
      new_input = 1'b0;
      chk("c_reaccept", {busy_t, timeout_err_t}, 2'b10);
      // Abort during section 5 guard cycle.
      do_reset();
      slave_mask = '1; ready = '1; nst = 0;
      for (int c = 1; c <= 22; c++) begin
         new_input = (c == 1);
         step();
         nst += int'(start);
      end
      new_input = 1'b0;
      chk("d_starts", nst, 6);
      chk("d_pre_sect", sectnum, 4'd5);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("d_abort", {busy, start, sectnum, frame_done}, 0);
      quiet = 0;
      repeat (70) begin
         step();
         quiet += int'(start) + int'(frame_done) + int'(busy);
      end
      chk("d_quiet", quiet, 0);
      // Reset in section 7, then a clean frame.
      do_reset();
      slave_mask = '1; ready = '1; res = 9'h1ff; corner = 36'hF_FFFF_FFFF;
      for (int c = 1; c <= 29; c++) begin
         new_input = (c == 1);
         step();
      end
      new_input = 1'b0;
      chk("e_sect7", {start, sectnum}, {1'b1, 4'd7});
      rst = 1'b1;
      step();
      chk("e_rst_outs", {start, sectnum, res_q, corner_q, busy, frame_done, timeout_err, input_dropped}, 0);
      rst = 1'b0;
      run_frame(1'b0, 9'h0c3, 36'h3_C3C3_C3C3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/master_sequencer.md
# master_sequencer

Parametrised frame sequencer that accepts one rasterisation job (resolution plus corner data) and walks it through every section. For each section it pulses a common `start` to the array of ICB slave blocks, waits until every enabled slave reports ready, then advances the section number. It sits between the job source and the ICB slave array, and replaces the fixed 30-slave / 16-section controller. New behaviour: per-slave enable mask, ready guard cycle, watchdog timeout, abort, and job-accept status outputs.

## Interface
- `NUM_SLAVES`, 30, number of ICB slaves and width of `ready`/`slave_mask`
- `NUM_SECTS`, 16, sections per frame (≥2)
- `RES_W`, 9, width of `res`
- `CORNER_W`, 36, width of `corner`
- `TIMEOUT`, 1024, maximum WAIT cycles per section; 0 disables the watchdog
- `SECT_W`, $clog2(NUM_SECTS), derived width of `sectnum`

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: reset, synchronous, active-high
- `res` in RES_W: job resolution, sampled on accept
- `corner` in CORNER_W: job corner data, sampled on accept
- `new_input` in 1: job request, level-sampled each cycle
- `abort` in 1: cancel current frame
- `slave_mask` in NUM_SLAVES: 1 = slave participates; sampled on accept
- `ready` in NUM_SLAVES: per-slave done flag
- `start` out 1: one-cycle pulse per section
- `sectnum` out SECT_W: current section, 0..NUM_SECTS-1
- `res_q` out RES_W, `corner_q` out CORNER_W: latched job data, stable for the whole frame
- `busy` out 1: high in every state except IDLE
- `frame_done` out 1: one-cycle pulse after the last section completes
- `timeout_err` out 1: sticky watchdog flag
- `input_dropped` out 1: one-cycle pulse when `new_input` arrives while busy

## Operation
- Reset: state IDLE; every output 0, including `res_q`, `corner_q`, mask register, and watchdog count.
- IDLE:
  - `new_input`=1: latch `res`, `corner`, `slave_mask`; clear `timeout_err`; set `sectnum`=0; go to START.
- START: `start`=1 for exactly one cycle; go to WAIT; watchdog count cleared.
- WAIT:
  - First cycle is a guard cycle: `ready` is ignored, so slaves have one cycle to drop a stale ready.
  - From the second cycle, if `&(ready | ~mask_q)`, go to CHECK.
  - An all-zero mask therefore exits after the guard cycle.
  - Watchdog increments each WAIT cycle. When count reaches TIMEOUT with no completion (TIMEOUT≠0), set `timeout_err` and go to IDLE without `frame_done`.
- CHECK:
  - If `sectnum`==NUM_SECTS-1, go to DONE.
  - Otherwise `sectnum`+1 and go to START.
- DONE: `frame_done`=1; `sectnum` cleared to 0; go to IDLE.
- `abort`=1 in any non-IDLE state:
  - Next state IDLE, `sectnum`=0.
  - No `start`, no `frame_done`.
  - `timeout_err` unchanged.
  - `abort` has priority over every other transition.
- `new_input` while busy (or in the same cycle as `abort`): job ignored, `input_dropped`=1 for that cycle.
- `new_input` in the DONE cycle is also dropped; the next job is accepted only from IDLE.
- `res_q`/`corner_q` hold their value after the frame until the next accept.
- `sectnum` never exceeds NUM_SECTS-1 and never wraps.

## Timing
- Accept at edge t0 → START at t0+1. With slaves ready immediately, each section takes 4 cycles: START, guard, WAIT-hit, CHECK.
- Last CHECK at t0+4·NUM_SECTS; `frame_done` at t0+4·NUM_SECTS+1; IDLE at +2. For 16 sections: `frame_done` at t0+65.
- `start` rises exactly 4 cycles apart when ready is immediate.
- `sectnum` changes only at the CHECK→START edge, DONE, abort, or accept.
- All outputs are registered or decoded from registered state; no combinational path from `ready` to `start`.
- Timeout fires at guard cycle + TIMEOUT cycles, i.e. TIMEOUT+1 WAIT cycles after START.

## Structure
- Shared package `master_seq_pkg`:
  - state enum (IDLE, START, WAIT, CHECK, DONE)
  - default parameter constants
- One sub-module `sect_counter`:
  - parametrised SECT_W up-counter with clear and enable
  - terminal-count output (== NUM_SECTS-1)
- Watchdog counter stays inline.

## Test plan
- Default parameters, all-ones mask, ready held high → 16 `start` pulses 4 cycles apart, `sectnum` 0..15, `frame_done` at t0+65, `busy` low at t0+66.
- Mask 0x0000_0003, slaves 0–1 raise ready 10 cycles after each `start`, others held 0 → each section completes on slave 0/1 readiness alone; frame completes; `timeout_err`=0.
- TIMEOUT=8, ready held low → `timeout_err`=1 after 9 WAIT cycles in section 0, `busy` low, no `frame_done`; next accept clears `timeout_err`.
- `abort` asserted during section 5 WAIT → IDLE next cycle, `sectnum`=0, no `frame_done`, no further `start`.
- `new_input` pulsed in section 3 and in the DONE cycle → `input_dropped` each time; `res_q`/`corner_q` unchanged; frame completes normally.
- `rst` asserted mid-frame at section 7 → next cycle all outputs 0, state IDLE; a new job runs a full frame from section 0.
